// File: rtl/cond_pkg.sv
// Shared types for the banked ARM-style condition unit: condition codes,
// NZCV bit positions and the flag nibble type.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_HS = 4'b0010,
        COND_LO = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational ARM condition-code decode: cond + NZCV -> pass/fail.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       cond_ex
);

    logic n_s, z_s, c_s, v_s;

    assign n_s = flags[N_BIT];
    assign z_s = flags[Z_BIT];
    assign c_s = flags[C_BIT];
    assign v_s = flags[V_BIT];

    // Condition decode table
    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_ex = z_s;
            COND_NE: cond_ex = !z_s;
            COND_HS: cond_ex = c_s;
            COND_LO: cond_ex = !c_s;
            COND_MI: cond_ex = n_s;
            COND_PL: cond_ex = !n_s;
            COND_VS: cond_ex = v_s;
            COND_VC: cond_ex = !v_s;
            COND_HI: cond_ex = !z_s && c_s;
            COND_LS: cond_ex = z_s || !c_s;
            COND_GE: cond_ex = (n_s == v_s);
            COND_LT: cond_ex = (n_s != v_s);
            COND_GT: cond_ex = !z_s && (n_s == v_s);
            COND_LE: cond_ex = z_s || (n_s != v_s);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit_banked.sv
// Banked NZCV condition unit with squash counter and optional flag save-stack
// (enabled by defining COND_FLAG_STACK_EN).
module cond_unit_banked
    import cond_pkg::*;
#(
    parameter int NUM_BANKS   = 2,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 16,
    localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BANK_W-1:0] bank_sel,
    input  logic [3:0]        cond,
    input  logic [1:0]        flag_w,
    input  logic [3:0]        alu_flags,
    input  logic              reg_w,
    input  logic              mem_w,
    input  logic              pc_s,
    input  logic              push,
    input  logic              pop,
    output logic              reg_write,
    output logic              mem_write,
    output logic              pc_src,
    output logic              cond_ex,
    output logic [3:0]        flags,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err,
    output logic [CNT_W-1:0]  squash_cnt
);

    flags_t           bank_q [NUM_BANKS];
    flags_t           bank_d [NUM_BANKS];
    logic [CNT_W-1:0] squash_q, squash_d;
    logic             bank_valid_s;
    flags_t           cur_flags_s;
    logic             cond_raw_s;

    assign bank_valid_s = (32'(bank_sel) < NUM_BANKS);
    assign cur_flags_s  = bank_valid_s ? bank_q[bank_sel] : 4'b0000;

    cond_eval u_cond_eval (
        .cond    (cond),
        .flags   (cur_flags_s),
        .cond_ex (cond_raw_s)
    );

    assign cond_ex   = cond_raw_s && bank_valid_s;
    assign reg_write = reg_w && cond_ex;
    assign mem_write = mem_w && cond_ex;
    assign pc_src    = pc_s && cond_ex;
    assign flags     = cur_flags_s;
    assign squash_cnt = squash_q;

`ifdef COND_FLAG_STACK_EN
    localparam int PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    flags_t           stack_q [STACK_DEPTH];
    flags_t           stack_d [STACK_DEPTH];
    logic [PTR_W-1:0] occ_q, occ_d, occ_m1_s;
    logic             full_q, full_d, empty_q, empty_d, err_q, err_d;

    assign occ_m1_s    = occ_q - PTR_W'(1);
    assign stack_full  = full_q;
    assign stack_empty = empty_q;
    assign stack_err   = err_q;
`else
    logic unused_stack_s;
    assign unused_stack_s = push ^ pop;
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_err   = 1'b0;
`endif

    // Next-state: flag update, stack traffic (pop overrides the update), squash count
    always_comb begin
        bank_d   = bank_q;
        squash_d = squash_q;
        if (cond_ex) begin
            if (flag_w[1]) begin
                bank_d[bank_sel][3:2] = alu_flags[3:2];
            end else begin
                bank_d[bank_sel][3:2] = bank_q[bank_sel][3:2];
            end
            if (flag_w[0]) begin
                bank_d[bank_sel][1:0] = alu_flags[1:0];
            end else begin
                bank_d[bank_sel][1:0] = bank_q[bank_sel][1:0];
            end
        end else begin
            bank_d = bank_q;
        end
`ifdef COND_FLAG_STACK_EN
        stack_d = stack_q;
        occ_d   = occ_q;
        err_d   = 1'b0;
        if (push && pop) begin
            err_d = 1'b1;
        end else if (push) begin
            if (full_q) begin
                err_d = 1'b1;
            end else begin
                stack_d[occ_q[IDX_W-1:0]] = cur_flags_s;
                occ_d = occ_q + PTR_W'(1);
            end
        end else if (pop) begin
            if (empty_q) begin
                err_d = 1'b1;
            end else begin
                if (bank_valid_s) begin
                    bank_d[bank_sel] = stack_q[occ_m1_s[IDX_W-1:0]];
                end else begin
                    bank_d = bank_d;
                end
                occ_d = occ_m1_s;
            end
        end else begin
            occ_d = occ_q;
        end
        full_d  = (occ_d == PTR_W'(STACK_DEPTH));
        empty_d = (occ_d == PTR_W'(0));
`endif
        if (!cond_ex && (reg_w || mem_w || pc_s) && (squash_q != {CNT_W{1'b1}})) begin
            squash_d = squash_q + CNT_W'(1);
        end else begin
            squash_d = squash_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_q[b] <= 4'b0000;
            end
            squash_q <= '0;
`ifdef COND_FLAG_STACK_EN
            for (int s = 0; s < STACK_DEPTH; s++) begin
                stack_q[s] <= 4'b0000;
            end
            occ_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
`endif
        end else begin
            bank_q   <= bank_d;
            squash_q <= squash_d;
`ifdef COND_FLAG_STACK_EN
            stack_q <= stack_d;
            occ_q   <= occ_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_cond_unit_banked.sv
// Directed self-checking bench for cond_unit_banked; covers the flag stack
// when COND_FLAG_STACK_EN is defined, otherwise its disabled behaviour.
module tb_cond_unit_banked;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:0]  bank_sel;
    logic [3:0]  cond, alu_flags;
    logic [1:0]  flag_w;
    logic        reg_w, mem_w, pc_s, push, pop;
    logic        reg_write, mem_write, pc_src, cond_ex;
    logic [3:0]  flags;
    logic        stack_full, stack_empty, stack_err;
    logic [15:0] squash_cnt;
    logic        b_reg_write, b_mem_write, b_pc_src, b_cond_ex;
    logic [3:0]  b_flags;
    logic        b_full, b_empty, b_err;
    logic [1:0]  b_squash;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cond_unit_banked #(.NUM_BANKS(2), .STACK_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bank_sel(bank_sel), .cond(cond),
        .flag_w(flag_w), .alu_flags(alu_flags), .reg_w(reg_w), .mem_w(mem_w),
        .pc_s(pc_s), .push(push), .pop(pop), .reg_write(reg_write),
        .mem_write(mem_write), .pc_src(pc_src), .cond_ex(cond_ex), .flags(flags),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err),
        .squash_cnt(squash_cnt)
    );

    cond_unit_banked #(.NUM_BANKS(2), .STACK_DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bank_sel(bank_sel), .cond(cond),
        .flag_w(flag_w), .alu_flags(alu_flags), .reg_w(reg_w), .mem_w(mem_w),
        .pc_s(pc_s), .push(push), .pop(pop), .reg_write(b_reg_write),
        .mem_write(b_mem_write), .pc_src(b_pc_src), .cond_ex(b_cond_ex), .flags(b_flags),
        .stack_full(b_full), .stack_empty(b_empty), .stack_err(b_err),
        .squash_cnt(b_squash)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cond = 4'b1110; flag_w = 2'b00; alu_flags = 4'b0000;
        reg_w = 1'b0; mem_w = 1'b0; pc_s = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; bank_sel = 1'b0;
        idle();
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_empty", 32'(stack_empty), 32'h1);
        chk("rst_full", 32'(stack_full), 32'h0);
        chk("rst_err", 32'(stack_err), 32'h0);
        chk("rst_squash", 32'(squash_cnt), 32'h0);

        // AL passes, EQ fails on reset flags; squashes counted
        reg_w = 1'b1; #1;
        chk("al_reg_write", 32'(reg_write), 32'h1);
        tick();
        chk("al_no_squash", 32'(squash_cnt), 32'h0);
        cond = 4'b0000; #1;
        chk("eq_reg_write", 32'(reg_write), 32'h0);
        chk("eq_cond_ex", 32'(cond_ex), 32'h0);
        tick();
        chk("squash_1", 32'(squash_cnt), 32'h1);
        reg_w = 1'b0; mem_w = 1'b1; #1;
        chk("eq_mem_write", 32'(mem_write), 32'h0);
        tick();
        mem_w = 1'b0; pc_s = 1'b1; #1;
        chk("eq_pc_src", 32'(pc_src), 32'h0);
        tick();
        chk("squash_3_sat", 32'(b_squash), 32'h3);
        tick();
        chk("squash_4", 32'(squash_cnt), 32'h4);
        chk("squash_sat_hold", 32'(b_squash), 32'h3);
        pc_s = 1'b0;
        tick();
        chk("squash_idle", 32'(squash_cnt), 32'h4);

        // Flag writes on bank 0, bank 1 untouched
        idle(); flag_w = 2'b10; alu_flags = 4'b0100;
        tick();
        chk("bank0_nz", 32'(flags), 32'h4);
        idle(); bank_sel = 1'b1; #1;
        chk("bank1_hold", 32'(flags), 32'h0);
        bank_sel = 1'b0; cond = 4'b0000; #1;
        chk("bank0_eq", 32'(cond_ex), 32'h1);
        cond = 4'b1110; flag_w = 2'b01; alu_flags = 4'b1111;
        tick();
        chk("bank0_cv", 32'(flags), 32'h7);
        cond = 4'b0001; flag_w = 2'b11; alu_flags = 4'b1000; #1;
        chk("ne_fail", 32'(cond_ex), 32'h0);
        tick();
        chk("ne_no_update", 32'(flags), 32'h7);

        // Signed conditions on bank 1 with N=1, V=0
        idle(); bank_sel = 1'b1; flag_w = 2'b11; alu_flags = 4'b1000;
        tick();
        idle();
        chk("bank1_n", 32'(flags), 32'h8);
        cond = 4'b1011; #1; chk("lt", 32'(cond_ex), 32'h1);
        cond = 4'b1010; #1; chk("ge", 32'(cond_ex), 32'h0);
        cond = 4'b1100; #1; chk("gt", 32'(cond_ex), 32'h0);
        cond = 4'b1101; #1; chk("le", 32'(cond_ex), 32'h1);
        cond = 4'b0100; #1; chk("mi", 32'(cond_ex), 32'h1);
        cond = 4'b1111; pc_s = 1'b1; #1; chk("nv_pc_src", 32'(pc_src), 32'h0);
        pc_s = 1'b0;
        bank_sel = 1'b0;
        cond = 4'b1000; #1; chk("hi", 32'(cond_ex), 32'h0);
        cond = 4'b1001; #1; chk("ls", 32'(cond_ex), 32'h1);
        idle();

`ifdef COND_FLAG_STACK_EN
        // Five pushes with changing bank value: full after 4, error on 5th
        flag_w = 2'b11;
        push = 1'b1; alu_flags = 4'b0001; tick(); chk("push1_bank", 32'(flags), 32'h1);
        alu_flags = 4'b0010; tick();
        alu_flags = 4'b0011; tick(); chk("push3_full", 32'(stack_full), 32'h0);
        alu_flags = 4'b0100; tick(); chk("push4_full", 32'(stack_full), 32'h1);
        flag_w = 2'b00; tick();
        chk("push5_err", 32'(stack_err), 32'h1);
        chk("push5_full", 32'(stack_full), 32'h1);
        push = 1'b0; tick();
        chk("err_one_cycle", 32'(stack_err), 32'h0);
        // LIFO pops; first pop overrides a simultaneous flag write
        pop = 1'b1; flag_w = 2'b11; alu_flags = 4'b1111;
        tick(); chk("pop1", 32'(flags), 32'h3);
        flag_w = 2'b00;
        tick(); chk("pop2", 32'(flags), 32'h2);
        tick(); chk("pop3", 32'(flags), 32'h1);
        tick(); chk("pop4", 32'(flags), 32'h7);
        chk("pop4_empty", 32'(stack_empty), 32'h1);
        tick();
        chk("pop5_err", 32'(stack_err), 32'h1);
        chk("pop5_empty", 32'(stack_empty), 32'h1);
        chk("pop5_flags", 32'(flags), 32'h7);
        // push+pop together is an error and leaves occupancy at 1
        pop = 1'b0; push = 1'b1; tick();
        pop = 1'b1; tick();
        chk("pp_err", 32'(stack_err), 32'h1);
        chk("pp_empty", 32'(stack_empty), 32'h0);
        push = 1'b0; flag_w = 2'b11; alu_flags = 4'b0000; tick(); pop = 1'b0; flag_w = 2'b00;
        chk("pp_pop_val", 32'(flags), 32'h7);
        chk("pp_pop_empty", 32'(stack_empty), 32'h1);
        push = 1'b1; tick();
        chk("mid_not_empty", 32'(stack_empty), 32'h0);
`else
        // Stack disabled: push/pop ignored, flag write still lands
        push = 1'b1; tick();
        chk("dis_err", 32'(stack_err), 32'h0);
        chk("dis_empty", 32'(stack_empty), 32'h1);
        push = 1'b0; pop = 1'b1; flag_w = 2'b11; alu_flags = 4'b1111; tick();
        chk("dis_pop_ignored", 32'(flags), 32'hf);
        chk("dis_full", 32'(stack_full), 32'h0);
        idle(); push = 1'b1;
`endif
        // Reset wins over push and flag write
        rst_n = 1'b0; flag_w = 2'b11; alu_flags = 4'b1111;
        tick();
        chk("rst_mid_flags", 32'(flags), 32'h0);
        chk("rst_mid_empty", 32'(stack_empty), 32'h1);
        chk("rst_mid_full", 32'(stack_full), 32'h0);
        chk("rst_mid_err", 32'(stack_err), 32'h0);
        chk("rst_mid_squash", 32'(squash_cnt), 32'h0);
        chk("rst_mid_sat", 32'(b_squash), 32'h0);
        idle(); rst_n = 1'b1;
        cond = 4'b0000; #1;
        chk("rst_eq_fail", 32'(cond_ex), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
